quad_event_arbiter: RTL and testbench

Collects single-cycle step pulses from NUM_CH quadrature decoder instances (one cw/ccw pulse pair per encoder), accumulates a signed per-channel step delta, and shares one valid/ready output channel among them with a round-robin arbiter. Sits between the bank of quadrature decoders and the downstream consumer (position/settings logic), so that the consumer sees one delta update at a time and no steps are lost while it stalls.

---
 rtl/quad_event_arbiter.sv | 126 ++++++++++++
 tb/tb_quad_event_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_event_arbiter.sv
// Per-channel signed step accumulators for a bank of quadrature decoders,
// drained one delta at a time through a round-robin valid/ready channel.

module qea_lane #(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cw,
    input  logic                 ccw,
    input  logic                 take,
    input  logic                 clr_ovf,
    output logic signed [DW-1:0] acc,
    output logic                 ovf
);
    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    logic up, dn, sat_ev;
    assign up = cw & ~ccw;
    assign dn = ccw & ~cw;
    // A step in the grant cycle restarts the accumulator and can never saturate.
    assign sat_ev = ~take & ((up & (acc == MAXV)) | (dn & (acc == MINV)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            if (take)
                acc <= up ? DW'(1) : (dn ? '1 : '0);
            else if (!sat_ev && up)
                acc <= acc + DW'(1);
            else if (!sat_ev && dn)
                acc <= acc - DW'(1);
            ovf <= sat_ev | (ovf & ~clr_ovf);
        end
    end
endmodule

module quad_event_arbiter #(
    parameter  int NUM_CH  = 4,
    parameter  int DW      = 8,
    localparam int CW_BITS = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         cw,
    input  logic [NUM_CH-1:0]         ccw,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW_BITS-1:0]        out_ch,
    output logic signed [DW-1:0]      out_delta,
    output logic [NUM_CH-1:0]         overflow,
    input  logic                      clr_ovf
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t                     state, state_nxt;
    logic [CW_BITS-1:0]         ptr;
    logic [NUM_CH-1:0][DW-1:0]  acc;
    logic [NUM_CH-1:0]          cand;
    logic                       found, grant;
    logic [CW_BITS-1:0]         gnt_idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign cand[i] = |acc[i];
        qea_lane #(.DW(DW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .cw      (cw[i]),
            .ccw     (ccw[i]),
            .take    (grant && (gnt_idx == CW_BITS'(i))),
            .clr_ovf (clr_ovf),
            .acc     (acc[i]),
            .ovf     (overflow[i])
        );
    end

    // Search order ptr, ptr+1, ... wrapping at NUM_CH (which need not be a power of 2).
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && cand[j]) begin
                found   = 1'b1;
                gnt_idx = CW_BITS'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE:  if (found) begin
                       grant     = 1'b1;
                       state_nxt = OFFER;
                   end
            OFFER: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == OFFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            out_ch    <= '0;
            out_delta <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                out_ch    <= gnt_idx;
                out_delta <= acc[gnt_idx];
            end
            if (out_valid && out_ready)
                ptr <= (out_ch == CW_BITS'(NUM_CH-1)) ? '0 : out_ch + 1'b1;
        end
    end
endmodule

// File: tb/tb_quad_event_arbiter.sv
// Directed bench for quad_event_arbiter: latency, round-robin order,
// saturation/overflow, cancelling steps, grant-cycle steps and async reset.

module tb_quad_event_arbiter;
    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cw, ccw;
    logic              out_valid, out_ready, clr_ovf;
    logic [1:0]        out_ch;
    logic signed [7:0] out_delta;
    logic [3:0]        overflow;

    int n_chk = 0;
    int n_fail = 0;

    quad_event_arbiter #(.NUM_CH(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .cw(cw), .ccw(ccw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_delta(out_delta),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cw = '0; ccw = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({out_valid, out_ch, out_delta, overflow} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b ch=%0d d=%0d ovf=%b want all 0",
                     out_valid, out_ch, out_delta, overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cw = 4'b0001;
        cyc(3);
        cw = '0;
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd0, 8'sd1}) begin
            n_fail++;
            $display("FAIL basic_first got v=%b ch=%0d d=%0d want v=1 ch=0 d=1", out_valid, out_ch, out_delta);
        end
        cyc(2);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd0, 8'sd1}) begin
            n_fail++;
            $display("FAIL basic_hold got v=%b ch=%0d d=%0d want v=1 ch=0 d=1", out_valid, out_ch, out_delta);
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_gap got v=%b want 0", out_valid);
        end
        cyc(1);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd0, 8'sd2}) begin
            n_fail++;
            $display("FAIL basic_second got v=%b ch=%0d d=%0d want v=1 ch=0 d=2", out_valid, out_ch, out_delta);
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_drained cycle %0d got v=%b want 0", k, out_valid);
            end
            cyc(1);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        // Park the arbiter on ch3 so ch1 and ch2 build up concurrently.
        cw = 4'b1000;
        cyc(1);
        cw = 4'b0010; ccw = 4'b0100;
        cyc(1);
        cw = '0;
        cyc(2);
        ccw = '0;
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd3, 8'sd1}) begin
            n_fail++;
            $display("FAIL rr_park got v=%b ch=%0d d=%0d want v=1 ch=3 d=1", out_valid, out_ch, out_delta);
        end
        out_ready = 1'b1;
        cyc(1);
        cyc(1);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd1, 8'sd1}) begin
            n_fail++;
            $display("FAIL rr_ch1 got v=%b ch=%0d d=%0d want v=1 ch=1 d=1", out_valid, out_ch, out_delta);
        end
        cyc(1);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle got v=%b want 0", out_valid);
        end
        cyc(1);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd2, -8'sd3}) begin
            n_fail++;
            $display("FAIL rr_ch2 got v=%b ch=%0d d=%0d want v=1 ch=2 d=-3", out_valid, out_ch, out_delta);
        end
        cyc(1);
        cw = 4'b0011;
        cyc(1);
        cw = '0;
        cyc(1);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd0, 8'sd1}) begin
            n_fail++;
            $display("FAIL rr_wrap got v=%b ch=%0d d=%0d want v=1 ch=0 d=1", out_valid, out_ch, out_delta);
        end
        cyc(2);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd1, 8'sd1}) begin
            n_fail++;
            $display("FAIL rr_after_wrap got v=%b ch=%0d d=%0d want v=1 ch=1 d=1", out_valid, out_ch, out_delta);
        end
        cyc(1);
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        cw = 4'b1000;
        cyc(128);
        n_chk++;
        if (overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_at_limit got ovf=%b want 0000", overflow);
        end
        cyc(2);
        cw = '0;
        n_chk++;
        if ({overflow, out_valid, out_ch, out_delta} !== {4'b1000, 1'b1, 2'd3, 8'sd1}) begin
            n_fail++;
            $display("FAIL sat_overflow got ovf=%b v=%b ch=%0d d=%0d want ovf=1000 v=1 ch=3 d=1",
                     overflow, out_valid, out_ch, out_delta);
        end
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        n_chk++;
        if (overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_clear got ovf=%b want 0000", overflow);
        end
        cw = 4'b1000; clr_ovf = 1'b1;
        cyc(1);
        cw = '0; clr_ovf = 1'b0;
        n_chk++;
        if (overflow !== 4'b1000) begin
            n_fail++;
            $display("FAIL sat_clear_vs_set got ovf=%b want 1000", overflow);
        end
        out_ready = 1'b1;
        cyc(2);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd3, 8'sd127}) begin
            n_fail++;
            $display("FAIL sat_drain got v=%b ch=%0d d=%0d want v=1 ch=3 d=127", out_valid, out_ch, out_delta);
        end
        cyc(1);
        out_ready = 1'b0;
    endtask

    task automatic test_cancel();
        // Runs right after saturation: overflow[3] is still set, all acc zero.
        cw = 4'b0100; ccw = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (k == 4) begin cw = '0; ccw = '0; end
            n_chk++;
            if ({out_valid, overflow} !== {1'b0, 4'b1000}) begin
                n_fail++;
                $display("FAIL cancel cycle %0d got v=%b ovf=%b want v=0 ovf=1000", k, out_valid, overflow);
            end
        end
    endtask

    task automatic test_grant_cycle_step();
        do_reset();
        cw = 4'b0001;
        cyc(1);
        cw = 4'b0010;
        cyc(4);
        cw = '0;
        out_ready = 1'b1;
        cyc(1);
        ccw = 4'b0010;
        cyc(1);
        ccw = '0;
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd1, 8'sd4}) begin
            n_fail++;
            $display("FAIL gstep_offer got v=%b ch=%0d d=%0d want v=1 ch=1 d=4", out_valid, out_ch, out_delta);
        end
        cyc(2);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd1, -8'sd1}) begin
            n_fail++;
            $display("FAIL gstep_kept got v=%b ch=%0d d=%0d want v=1 ch=1 d=-1", out_valid, out_ch, out_delta);
        end
        cyc(1);
        out_ready = 1'b0;
        cyc(1);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gstep_done got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        cw = 4'b0001;
        cyc(6);
        cw = '0;
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd0, 8'sd1}) begin
            n_fail++;
            $display("FAIL rstoff_pre got v=%b ch=%0d d=%0d want v=1 ch=0 d=1", out_valid, out_ch, out_delta);
        end
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, out_ch, out_delta, overflow} !== 15'd0) begin
            n_fail++;
            $display("FAIL rstoff_async got v=%b ch=%0d d=%0d ovf=%b want all 0",
                     out_valid, out_ch, out_delta, overflow);
        end
        cyc(1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstoff_discard cycle %0d got v=%b want 0", k, out_valid);
            end
        end
        out_ready = 1'b0;
        cw = 4'b0100;
        cyc(1);
        cw = '0;
        cyc(1);
        n_chk++;
        if ({out_valid, out_ch, out_delta} !== {1'b1, 2'd2, 8'sd1}) begin
            n_fail++;
            $display("FAIL rstoff_new got v=%b ch=%0d d=%0d want v=1 ch=2 d=1", out_valid, out_ch, out_delta);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_saturation();
        test_cancel();
        test_grant_cycle_step();
        test_reset_mid_offer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
